// File: rtl/gpl_status_pkg.sv
// ---------------------------------------------------------------------------
// gpl_status_pkg
// Shared definitions for the GPL status generator and the downstream
// fsm_gpl_status detector: default field widths and the state encoding.
// ---------------------------------------------------------------------------
package gpl_status_pkg;

    // Default widths of the hold/gap length fields and of the repeat field.
    localparam int GPL_CNT_W = 8;
    localparam int GPL_REP_W = 4;

    // Generator FSM states. The encoding is visible on the debug port, so
    // keep it stable.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } gpl_state_t;

endpackage : gpl_status_pkg

// File: rtl/gpl_down_cnt.sv
// ---------------------------------------------------------------------------
// gpl_down_cnt
// Loadable down-counter with a zero flag. It stops at zero instead of
// wrapping around.
//
// Ports:
//   clk      - system clock
//   arst     - synchronous active-high reset, clears the count
//   load     - load load_val (has priority over dec)
//   load_val - value to load
//   dec      - decrement by one when the count is non-zero
//   zero     - count is zero
// ---------------------------------------------------------------------------
module gpl_down_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (arst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule : gpl_down_cnt

// File: rtl/gpl_status_gen.sv
// ---------------------------------------------------------------------------
// gpl_status_gen
// Generates a burst of gpl_status pulses for the fsm_gpl_status detector.
// Each pulse is high for hold_len cycles. Pulses are separated by
// max(gap_len,1) low cycles. A burst contains repeat_n pulses.
//
// Ports:
//   clk        - system clock
//   arst       - synchronous active-high reset
//   ena        - generator enable; dropping it aborts a running burst
//   start      - one-cycle burst request
//   hold_len   - high cycles per pulse
//   gap_len    - low cycles between pulses (0 behaves as 1)
//   repeat_n   - number of pulses in the burst
//   specreg    - feedback from the detector
//   gpl_status - generated status level (registered)
//   busy       - burst in progress, including the DONE cycle
//   done       - one-cycle end-of-burst pulse
//   aborted    - valid with done; sticky until the next accepted start
//   ack_seen   - sticky; specreg was seen high while busy
//   dbg_state  - current FSM state (gpl_state_t encoding)
//
// Handshake: start is a request with no data phase. It is taken only when
// the FSM is in IDLE and ena=1 in the same cycle (implicit ready = !busy).
// A start outside that window is dropped, not queued. The parameters are
// captured on acceptance, so later changes on the inputs do not affect the
// running burst.
// ---------------------------------------------------------------------------
module gpl_status_gen
    import gpl_status_pkg::*;
#(
    parameter int CNT_W = GPL_CNT_W,
    parameter int REP_W = GPL_REP_W
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             ena,
    input  logic             start,
    input  logic [CNT_W-1:0] hold_len,
    input  logic [CNT_W-1:0] gap_len,
    input  logic [REP_W-1:0] repeat_n,
    input  logic             specreg,
    output logic             gpl_status,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             ack_seen,
    output logic [1:0]       dbg_state
);

    gpl_state_t       state;
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] gap_q;
    logic [CNT_W-1:0] gap_m1;

    // Counter control
    logic             len_load;
    logic [CNT_W-1:0] len_val;
    logic             len_dec;
    logic             len_zero;
    logic             rep_load;
    logic [REP_W-1:0] rep_val;
    logic             rep_dec;
    logic             rep_zero;

    logic accept;
    logic degenerate;

    assign accept     = (state == ST_IDLE) && start && ena;
    assign degenerate = (hold_len == '0) || (repeat_n == '0);
    // A zero gap is stretched to one cycle so that adjacent pulses stay separate.
    assign gap_m1     = (gap_q == '0) ? '0 : gap_q - CNT_W'(1);
    assign dbg_state  = state;

    // Both counters are loaded with (length - 1). A zero flag therefore marks
    // the last cycle of a phase, or the last pulse of the burst.
    always_comb begin
        len_load = 1'b0;
        len_val  = '0;
        len_dec  = 1'b0;
        rep_load = 1'b0;
        rep_val  = '0;
        rep_dec  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    len_load = 1'b1;
                    len_val  = hold_len - CNT_W'(1);
                    rep_load = 1'b1;
                    rep_val  = repeat_n - REP_W'(1);
                end
            end
            ST_HIGH: begin
                if (ena) begin
                    if (len_zero) begin
                        rep_dec = 1'b1;
                        if (!rep_zero) begin
                            len_load = 1'b1;
                            len_val  = gap_m1;
                        end
                    end else begin
                        len_dec = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (ena) begin
                    if (len_zero) begin
                        len_load = 1'b1;
                        len_val  = hold_q - CNT_W'(1);
                    end else begin
                        len_dec = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    gpl_down_cnt #(.W(CNT_W)) u_len_cnt (
        .clk      (clk),
        .arst     (arst),
        .load     (len_load),
        .load_val (len_val),
        .dec      (len_dec),
        .zero     (len_zero)
    );

    gpl_down_cnt #(.W(REP_W)) u_rep_cnt (
        .clk      (clk),
        .arst     (arst),
        .load     (rep_load),
        .load_val (rep_val),
        .dec      (rep_dec),
        .zero     (rep_zero)
    );

    always_ff @(posedge clk) begin
        if (arst) begin
            state      <= ST_IDLE;
            gpl_status <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            ack_seen   <= 1'b0;
            hold_q     <= '0;
            gap_q      <= '0;
        end else begin
            if (busy && specreg) begin
                ack_seen <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    gpl_status <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    if (accept) begin
                        hold_q   <= hold_len;
                        gap_q    <= gap_len;
                        ack_seen <= 1'b0;
                        aborted  <= 1'b0;
                        busy     <= 1'b1;
                        if (degenerate) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= ST_HIGH;
                            gpl_status <= 1'b1;
                        end
                    end
                end
                ST_HIGH: begin
                    if (!ena) begin
                        state      <= ST_DONE;
                        gpl_status <= 1'b0;
                        done       <= 1'b1;
                        aborted    <= 1'b1;
                    end else if (len_zero) begin
                        gpl_status <= 1'b0;
                        if (rep_zero) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (!ena) begin
                        state      <= ST_DONE;
                        gpl_status <= 1'b0;
                        done       <= 1'b1;
                        aborted    <= 1'b1;
                    end else if (len_zero) begin
                        state      <= ST_HIGH;
                        gpl_status <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    gpl_status <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : gpl_status_gen

// File: tb/tb_gpl_status_gen.sv
`timescale 1ns/1ps
module tb_gpl_status_gen;
    import gpl_status_pkg::*;

    localparam int CNT_W = 8;
    localparam int REP_W = 4;

    // ---------------- clock / reset / signals ----------------
    logic             clk = 1'b0;
    logic             arst = 1'b1;
    logic             ena = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] hold_len = '0;
    logic [CNT_W-1:0] gap_len = '0;
    logic [REP_W-1:0] repeat_n = '0;
    logic             specreg = 1'b0;
    logic             gpl_status;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             ack_seen;
    logic [1:0]       dbg_state;

    always #5 clk = ~clk;

    gpl_status_gen #(.CNT_W(CNT_W), .REP_W(REP_W)) dut (
        .clk        (clk),
        .arst       (arst),
        .ena        (ena),
        .start      (start),
        .hold_len   (hold_len),
        .gap_len    (gap_len),
        .repeat_n   (repeat_n),
        .specreg    (specreg),
        .gpl_status (gpl_status),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .ack_seen   (ack_seen),
        .dbg_state  (dbg_state)
    );

    // Simple detector stand-in: answers after four consecutive high cycles.
    bit det_en = 1'b0;
    int hi_run = 0;
    always @(negedge clk) begin
        if (gpl_status === 1'b1) hi_run = hi_run + 1;
        else                     hi_run = 0;
        specreg = det_en && (hi_run >= 4);
    end

    // ---------------- scoreboard ----------------
    // Expected per-cycle vector {gpl_status, busy, done, aborted}
    logic [3:0] exp_q[$];
    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_n(input logic [3:0] v, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(v);
    endtask

    // Reference pulse train for a burst started with ena held high.
    task automatic push_burst(input int hold, input int gap, input int rep);
        if (hold == 0 || rep == 0) begin
            push_n(4'b0110, 1);
        end else begin
            for (int p = 0; p < rep; p++) begin
                push_n(4'b1100, hold);
                if (p < rep - 1) push_n(4'b0100, (gap == 0) ? 1 : gap);
            end
            push_n(4'b0110, 1);
        end
        push_n(4'b0000, 1);
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge where the first result is visible.
    task automatic drive_start(input int h, input int g, input int r);
        hold_len = CNT_W'(h);
        gap_len  = CNT_W'(g);
        repeat_n = REP_W'(r);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Pops and compares one vector per cycle. act_kind: 0 none, 1 drop ena,
    // 2 extra start, 3 reset. The action is applied after compare index act_idx.
    task automatic drain(input string name, input int act_idx, input int act_kind);
        int i;
        logic [3:0] e;
        i = 0;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_val($sformatf("%s[%0d]", name, i), {gpl_status, busy, done, aborted}, e);
            if (act_kind != 0 && i == act_idx) begin
                case (act_kind)
                    1: ena   = 1'b0;
                    2: start = 1'b1;
                    3: arst  = 1'b1;
                    default: ;
                endcase
            end
            if (act_kind != 0 && i == act_idx + 1) begin
                start = 1'b0;
                arst  = 1'b0;
            end
            i++;
            @(negedge clk);
        end
        ena   = 1'b1;
        start = 1'b0;
        arst  = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_outputs", {gpl_status, busy, done, aborted, ack_seen}, 5'b0);
        check_val("rst_state", dbg_state, ST_IDLE);
        arst = 1'b0;
        @(negedge clk);

        // Normal burst: 1,1,1,0,0,1,1,1 then done
        drive_start(3, 2, 2);
        check_val("norm_state", dbg_state, ST_HIGH);
        push_burst(3, 2, 2);
        drain("normal", 0, 0);

        // Degenerate requests
        drive_start(5, 1, 0);
        push_burst(5, 1, 0);
        drain("degen_rep0", 0, 0);
        drive_start(0, 1, 3);
        push_burst(0, 1, 3);
        drain("degen_hold0", 0, 0);

        // Abort in the second gap cycle
        drive_start(8, 4, 3);
        push_n(4'b1100, 8);
        push_n(4'b0100, 2);
        push_n(4'b0110 | 4'b0001, 1);
        push_n(4'b0001, 2);
        drain("abort", 9, 1);

        // Reset in idle clears the sticky aborted flag
        arst = 1'b1;
        @(negedge clk);
        arst = 1'b0;
        check_val("rst_clears_aborted", aborted, 1'b0);

        // Reset mid-HIGH at the 4th high cycle
        drive_start(10, 1, 1);
        push_n(4'b1100, 4);
        push_n(4'b0000, 3);
        drain("rst_mid", 3, 3);
        check_val("rst_mid_state", dbg_state, ST_IDLE);

        // Zero gap plus an ignored mid-burst start with changed inputs
        drive_start(2, 0, 2);
        hold_len = 8'd5;
        gap_len  = 8'd3;
        repeat_n = 4'd4;
        push_burst(2, 0, 2);
        push_n(4'b0000, 3);
        drain("ign_start", 1, 2);

        // start with ena low in IDLE: nothing happens
        ena   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ena   = 1'b1;
        push_n(4'b0000, 3);
        drain("start_no_ena", 0, 0);

        // Reset has priority over start
        hold_len = 8'd4;
        repeat_n = 4'd1;
        arst  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        arst  = 1'b0;
        start = 1'b0;
        push_n(4'b0000, 3);
        drain("rst_prio", 0, 0);

        // Loopback with the detector stand-in
        check_val("ack_before", ack_seen, 1'b0);
        det_en = 1'b1;
        drive_start(9, 0, 1);
        push_burst(9, 0, 1);
        drain("loop", 0, 0);
        det_en = 1'b0;
        check_val("ack_set", ack_seen, 1'b1);
        @(negedge clk);
        check_val("ack_sticky", ack_seen, 1'b1);
        drive_start(0, 0, 1);
        push_burst(0, 0, 1);
        drain("ack_clr_burst", 0, 0);
        check_val("ack_cleared", ack_seen, 1'b0);

        // Maximum hold and repeat
        drive_start(255, 1, 15);
        push_burst(255, 1, 15);
        drain("max", 0, 0);

        // Random bursts
        for (int t = 0; t < 6; t++) begin
            int h, g, r;
            h = $urandom_range(0, 6);
            g = $urandom_range(0, 3);
            r = $urandom_range(0, 3);
            drive_start(h, g, r);
            push_burst(h, g, r);
            drain($sformatf("rand%0d", t), 0, 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_gpl_status_gen
